// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit (MULTU, MULT, DIVU, DIV) feeding the HI/LO registers.
// Optional MDU_EARLY_TERM_EN: zero-operand ops bypass the iteration phase.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // state | meaning
    // IDLE  | waiting for start, operands latched on acceptance
    // CALC  | one product/quotient bit per cycle, WIDTH cycles
    // FIX   | sign correction, hi/lo loaded
    // DONE  | done pulse, hi/lo valid
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic                 op_div, sa, sb, dbz;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_rem;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_step, div_step, prod_fix;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    assign abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign abs_b = (op[0] && b[WIDTH-1]) ? -b : b;

`ifdef MDU_EARLY_TERM_EN
    logic skip;
    assign skip = op[1] ? (b == '0) : ((a == '0) || (b == '0));
`endif

    // Multiply: the multiplier sits in the low half and drains out as the sum shifts in.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: remainder high, quotient bits enter at the bottom of the low half.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_rem   = div_shift[WIDTH-1:0] - opnd;
    assign div_step  = div_ge ? {div_rem, acc[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    assign prod_fix = (sa ^ sb) ? -acc : acc;

    always_comb begin
        fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo = prod_fix[WIDTH-1:0];
        if (op_div) begin
            // Remainder negated by the dividend sign restores the original a on divide-by-zero.
            fix_hi = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            fix_lo = dbz ? '1 : ((sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CALC;
`ifdef MDU_EARLY_TERM_EN
                    if (skip) state_nxt = FIX;
`endif
                end
            end
            CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            op_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            dbz    <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div <= op[1];
                        sa     <= op[0] & a[WIDTH-1];
                        sb     <= op[0] & b[WIDTH-1];
                        dbz    <= op[1] && (b == '0);
                        opnd   <= op[1] ? abs_b : abs_a;
                        acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        cnt    <= '0;
`ifdef MDU_EARLY_TERM_EN
                        if (skip) acc <= op[1] ? {abs_a, {WIDTH{1'b1}}} : '0;
`endif
                    end
                end
                CALC: begin
                    acc <= op_div ? div_step : mul_step;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state == CALC) || (state == FIX);
    assign done        = (state == DONE);
    assign div_by_zero = (state == DONE) && dbz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int tests_run = 0;
    int tests_failed = 0;

`ifdef MDU_EARLY_TERM_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 34;
`endif

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Issues one op and observes it; cycle k is sampled 1 time unit after the k-th edge
    // counting the start-sampling edge as 1.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int dcyc, output logic [31:0] rh, output logic [31:0] rl,
                          output logic rdbz, output int bcnt, output int bfirst,
                          output int blast, output int dlen, output logic stray);
        dcyc = 0; rh = '0; rl = '0; rdbz = 1'b0; bcnt = 0; bfirst = 0; blast = 0;
        dlen = 0; stray = 1'b0;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (busy) begin
                bcnt++;
                if (bfirst == 0) bfirst = k;
                blast = k;
            end
            if (done) begin
                dlen++;
                if (dcyc == 0) begin
                    dcyc = k; rh = hi; rl = lo; rdbz = div_by_zero;
                end
            end else if (div_by_zero) begin
                stray = 1'b1;
            end
            if (dcyc != 0 && k >= dcyc + 3) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags got busy/done/dbz=%b expected 000", {busy, done, div_by_zero});
        end
        tests_run++;
        if ({hi, lo} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_hilo got hi=%h lo=%h expected 0/0", hi, lo);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max;
        int dc, bc, bf, bl, dl; logic [31:0] h, l; logic z, s;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (dc !== 34) begin tests_failed++; $display("FAIL multu_latency got %0d expected 34", dc); end
        tests_run++;
        if ({h, l} !== 64'hFFFF_FFFE_0000_0001) begin
            tests_failed++; $display("FAIL multu_result got hi=%h lo=%h expected fffffffe/00000001", h, l);
        end
        tests_run++;
        if (bc !== 33 || bf !== 1 || bl !== 33) begin
            tests_failed++; $display("FAIL multu_busy got count=%0d first=%0d last=%0d expected 33/1/33", bc, bf, bl);
        end
        tests_run++;
        if (dl !== 1) begin tests_failed++; $display("FAIL multu_done_pulse got %0d cycles expected 1", dl); end
        tests_run++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            tests_failed++; $display("FAIL multu_hold got hi=%h lo=%h expected fffffffe/00000001", hi, lo);
        end
    endtask

    task automatic test_signed;
        int dc, bc, bf, bl, dl; logic [31:0] h, l; logic z, s;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin
            tests_failed++; $display("FAIL mult_neg got hi=%h lo=%h expected ffffffff/ffffffeb", h, l);
        end
        run_op(2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (h !== 32'h0 || l !== 32'd30) begin
            tests_failed++; $display("FAIL mult_negneg got hi=%h lo=%h expected 00000000/0000001e", h, l);
        end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD || z !== 1'b0) begin
            tests_failed++; $display("FAIL div_neg got hi=%h lo=%h dbz=%b expected ffffffff/fffffffd/0", h, l, z);
        end
        run_op(2'b11, 32'd7, 32'hFFFF_FFFE, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (h !== 32'd1 || l !== 32'hFFFF_FFFD) begin
            tests_failed++; $display("FAIL div_negdivisor got hi=%h lo=%h expected 00000001/fffffffd", h, l);
        end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (h !== 32'h0 || l !== 32'h8000_0000 || z !== 1'b0 || dc !== 34) begin
            tests_failed++; $display("FAIL div_overflow got hi=%h lo=%h dbz=%b lat=%0d expected 00000000/80000000/0/34", h, l, z, dc);
        end
    endtask

    task automatic test_unsigned_div;
        int dc, bc, bf, bl, dl; logic [31:0] h, l; logic z, s;
        run_op(2'b10, 32'd100, 32'd7, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (h !== 32'd2 || l !== 32'd14 || dc !== 34) begin
            tests_failed++; $display("FAIL divu_basic got hi=%h lo=%h lat=%0d expected 00000002/0000000e/34", h, l, dc);
        end
    endtask

    task automatic test_div_by_zero;
        int dc, bc, bf, bl, dl; logic [31:0] h, l; logic z, s;
        run_op(2'b10, 32'd100, 32'd0, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (h !== 32'h64 || l !== 32'hFFFF_FFFF || z !== 1'b1) begin
            tests_failed++; $display("FAIL divu_zero got hi=%h lo=%h dbz=%b expected 00000064/ffffffff/1", h, l, z);
        end
        tests_run++;
        if (dc !== ZLAT || bc !== ZLAT - 1) begin
            tests_failed++; $display("FAIL divu_zero_latency got lat=%0d busy=%0d expected %0d/%0d", dc, bc, ZLAT, ZLAT - 1);
        end
        tests_run++;
        if (s !== 1'b0) begin tests_failed++; $display("FAIL dbz_stray got %b expected 0", s); end
        run_op(2'b11, 32'hFFFF_FFF0, 32'd0, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (h !== 32'hFFFF_FFF0 || l !== 32'hFFFF_FFFF || z !== 1'b1) begin
            tests_failed++; $display("FAIL div_zero_neg got hi=%h lo=%h dbz=%b expected fffffff0/ffffffff/1", h, l, z);
        end
        run_op(2'b00, 32'd0, 32'd5, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (h !== 32'h0 || l !== 32'h0 || z !== 1'b0 || dc !== ZLAT) begin
            tests_failed++; $display("FAIL multu_zero got hi=%h lo=%h dbz=%b lat=%0d expected 0/0/0/%0d", h, l, z, dc, ZLAT);
        end
    endtask

    // Start pulses while busy and during DONE must both be ignored.
    task automatic test_back_to_back;
        int dc; logic [31:0] h, l; logic extra;
        dc = 0; h = '0; l = '0; extra = 1'b0;
        @(negedge clk);
        op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (k == 9) begin op = 2'b01; a = 32'd3; b = 32'd3; start = 1'b1; end
            if (k == 10) start = 1'b0;
            if (dc != 0 && k > dc + 1 && (busy || done)) extra = 1'b1;
            if (dc != 0 && k == dc + 1) start = 1'b0;
            if (done && dc == 0) begin
                dc = k; h = hi; l = lo;
                op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
            end
        end
        start = 1'b0;
        tests_run++;
        if (dc !== 34 || h !== 32'h0 || l !== 32'd30) begin
            tests_failed++; $display("FAIL busy_ignore got lat=%0d hi=%h lo=%h expected 34/00000000/0000001e", dc, h, l);
        end
        tests_run++;
        if (extra !== 1'b0) begin tests_failed++; $display("FAIL done_start_ignored got extra activity=%b expected 0", extra); end
    endtask

    task automatic test_reset_abort;
        int dc, bc, bf, bl, dl; logic [31:0] h, l; logic z, s, saw_done, was_busy;
        saw_done = 1'b0; was_busy = 1'b0;
        @(negedge clk);
        op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (k == 9) begin a = 32'd3; b = 32'd3; start = 1'b1; end
            if (k == 10) start = 1'b0;
            if (done) saw_done = 1'b1;
            if (k == 19) was_busy = busy;
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (saw_done !== 1'b0 || was_busy !== 1'b1) begin
            tests_failed++; $display("FAIL abort_pre got done_seen=%b busy=%b expected 0/1", saw_done, was_busy);
        end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            tests_failed++; $display("FAIL abort_reset got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0", busy, done, hi, lo);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(2'b00, 32'd5, 32'd6, dc, h, l, z, bc, bf, bl, dl, s);
        tests_run++;
        if (dc !== 34 || h !== 32'h0 || l !== 32'd30) begin
            tests_failed++; $display("FAIL abort_rerun got lat=%0d hi=%h lo=%h expected 34/00000000/0000001e", dc, h, l);
        end
    endtask

    initial begin
        test_reset;
        test_multu_max;
        test_signed;
        test_unsigned_div;
        test_div_by_zero;
        test_back_to_back;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
